// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [2:0]      fn;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic            neg_q;
  logic            neg_r;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    rem;
  logic [W-1:0]    quo;

  logic            a_sgn;
  logic            b_sgn;
  logic            div_zero;
  logic            ovf;
  logic [W-1:0]    a_abs;
  logic [W-1:0]    b_abs;
  logic [W:0]      msum;
  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic            ge;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    qv;
  logic [W-1:0]    rv;
  logic [W-1:0]    res_next;

  assign a_sgn = op_a[W-1] & (funct3 == 3'b001 | funct3 == 3'b010 |
                              funct3 == 3'b100 | funct3 == 3'b110);
  assign b_sgn = op_b[W-1] & (funct3 == 3'b001 | funct3 == 3'b100 |
                              funct3 == 3'b110);
  assign a_abs = a_sgn ? -op_a : op_a;
  assign b_abs = b_sgn ? -op_b : op_b;

  assign div_zero = funct3[2] & (op_b == '0);
  assign ovf      = funct3[2] & ~funct3[0] &
                    (op_a == MIN) & (op_b == '1);

  assign msum    = {1'b0, acc[2*W-1:W]} + {1'b0, a_mag};
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, b_mag};
  assign ge      = shifted >= {1'b0, b_mag};

  assign prod = neg_q ? -acc : acc;
  assign qv   = neg_q ? -quo : quo;
  assign rv   = neg_r ? -rem : rem;

  always_comb begin
    res_next = '0;
    unique case (1'b1)
      fn == 3'b000:           res_next = prod[W-1:0];
      ~fn[2] & (fn != 3'b0):  res_next = prod[2*W-1:W];
      fn[2] & ~fn[1]:         res_next = qv;
      fn[2] & fn[1]:          res_next = rv;
      default:                res_next = '0;
    endcase
  end

  assign busy  = (state == CALC) | (state == DONE);
  // Gated by reset so the pipeline is released the instant reset hits
  assign stall = rst_n & ((start & (state == IDLE)) | (state == CALC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      fn     <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            fn  <= funct3;
            cnt <= '0;
            if (div_zero || ovf) begin
              // Fast path: preload so the DONE selection yields the answer
              quo   <= div_zero ? '1 : MIN;
              rem   <= div_zero ? op_a : '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else begin
              a_mag <= a_abs;
              b_mag <= b_abs;
              neg_q <= a_sgn ^ b_sgn;
              neg_r <= a_sgn;
              acc   <= {{W{1'b0}}, b_abs};
              rem   <= '0;
              quo   <= a_abs;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (fn[2]) begin
              rem <= ge ? diff[W-1:0] : shifted[W-1:0];
              quo <= {quo[W-2:0], ge};
            end else if (acc[0]) begin
              acc <= {msum, acc[W-1:1]};
            end else begin
              acc <= {1'b0, acc[2*W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W-1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!flush) begin
            done   <= 1'b1;
            result <= res_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Inputs driven and outputs sampled on the falling edge.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int cyc;
    int stalls;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    stalls = 0;
    #1;
    if (stall) stalls++;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (stall) stalls++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_stalls"}, 32'(stalls), (lat == 34) ? 32'd33 : 32'd1);
    chk({tag, "_result"}, result, exp);
  endtask

  initial begin
    int seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    flush  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("div", 3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34);
    run_op("rem", 3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 34);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    run_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 2);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

    // Flush part-way through a divide
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b100;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    repeat (10) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result", result, 32'h0);
    repeat (4) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // Async reset mid-operation with start held high
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd50;
    op_b   = 32'd5;
    @(negedge clk);
    funct3 = 3'b000;
    op_a   = 32'd9;
    seen   = 0;
    repeat (19) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("held_start_busy", 32'(busy), 32'd1);
    chk("held_start_stall", 32'(stall), 32'd1);
    chk("held_start_no_done", 32'(seen), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    run_op("divu_after_rst", 3'b101, 32'd50, 32'd5, 32'd10, 34);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
